regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 153 +++++++++++++++
 tb/tb_regfile_mp.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports (port 1 wins), NREAD async read ports,
// per-register pending scoreboard, and a sequential whole-file clear engine.
module regfile_mp #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 32,
  parameter  int NREAD  = 3,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we0,
  input  logic                   we1,
  input  logic [AW-1:0]          wa0,
  input  logic [AW-1:0]          wa1,
  input  logic [WIDTH-1:0]       wd0,
  input  logic [WIDTH-1:0]       wd1,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       rbusy,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_addr,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              idle, clearing;
  logic              c0, c1, c0_eff;

  // ---------------- clear FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- clear FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clr_req) state_d = S_CLEAR;
      S_CLEAR: if (idx_q == AW'(DEPTH - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- clear FSM: outputs ----------------
  always_comb begin
    idle      = (state_q == S_IDLE);
    clearing  = (state_q == S_CLEAR);
    dbg_state = state_q;
  end

  // Status flags are flops decoded from the next state, so they track state exactly
  // and have no combinational path from any input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_busy <= (state_d != S_IDLE);
      clr_done <= (state_d == S_DONE);
    end
  end

  // Index starts at 1 (register 0 is hardwired) and saturates at DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (idle && clr_req) begin
      idx_q <= AW'(1);
    end else if (clearing && idx_q != AW'(DEPTH - 1)) begin
      idx_q <= idx_q + AW'(1);
    end
  end

  // ---------------- write commit ----------------
  always_comb begin
    c0     = idle && we0 && (wa0 != '0);
    c1     = idle && we1 && (wa1 != '0);
    c0_eff = c0 && !(c1 && (wa1 == wa0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clearing) begin
      mem[idx_q] <= '0;
    end else begin
      if (c0_eff) mem[wa0] <= wd0;
      if (c1)     mem[wa1] <= wd1;
    end
  end

  // ---------------- scoreboard ----------------
  // Issue is applied after the write clear so a same-cycle issue keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clearing) begin
      busy_d[idx_q] = 1'b0;
    end else if (idle) begin
      if (c0) busy_d[wa0] = 1'b0;
      if (c1) busy_d[wa1] = 1'b0;
      if (iss_valid && iss_addr != '0) busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // ---------------- read ports ----------------
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] val;
    logic             fwd;

    assign a = ra[k*AW +: AW];

    always_comb begin
      val = mem[a];
      fwd = 1'b0;
      if (BYPASS != 0) begin
        if (c1 && wa1 == a) begin
          val = wd1;
          fwd = 1'b1;
        end else if (c0 && wa0 == a) begin
          val = wd0;
          fwd = 1'b1;
        end
      end
      if (a == '0) val = '0;
    end

    assign rd[k*WIDTH +: WIDTH] = val;
    assign rbusy[k]             = busy_q[a] & ~fwd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance and a small no-bypass instance share one
// stimulus stream; both are compared each cycle against an array-based reference model.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        we0, we1, iss_valid, clr_req;
  logic [4:0]  wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1;
  logic [4:0]  ra_v [4];

  logic [14:0] ra_a;
  logic [95:0] rd_a;
  logic [2:0]  rbusy_a;
  logic        clr_busy_a, clr_done_a;
  logic [1:0]  dbg_a;

  logic [11:0] ra_b;
  logic [63:0] rd_b;
  logic [3:0]  rbusy_b;
  logic        clr_busy_b, clr_done_b;
  logic [1:0]  dbg_b;

  assign ra_a = {ra_v[2], ra_v[1], ra_v[0]};
  assign ra_b = {ra_v[3][2:0], ra_v[2][2:0], ra_v[1][2:0], ra_v[0][2:0]};

  regfile_mp u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra(ra_a), .rd(rd_a), .rbusy(rbusy_a),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy_a), .clr_done(clr_done_a),
    .dbg_state(dbg_a)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(8), .NREAD(4), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .we1(we1), .wa0(wa0[2:0]), .wa1(wa1[2:0]), .wd0(wd0[15:0]), .wd1(wd1[15:0]),
    .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
    .iss_valid(iss_valid), .iss_addr(iss_addr[2:0]),
    .clr_req(clr_req), .clr_busy(clr_busy_b), .clr_done(clr_done_b),
    .dbg_state(dbg_b)
  );

  // ---------------- reference model ----------------
  // Instance 0: DEPTH 32, WIDTH 32, bypass. Instance 1: DEPTH 8, WIDTH 16, no bypass.
  // mcnt = cycles since a clear was accepted (0 = not clearing).
  logic [31:0] mr [2][32];
  logic        mb [2][32];
  int          mcnt [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int dep(input int n);
    return (n != 0) ? 8 : 32;
  endfunction

  function automatic logic [31:0] wmask(input int n);
    return (n != 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Is a write from port p committing to address a this cycle in instance n?
  function automatic bit m_hit(input int n, input int p, input int a);
    int  d    = dep(n);
    int  w    = (p != 0) ? (int'(wa1) & (d - 1)) : (int'(wa0) & (d - 1));
    bit  we   = (p != 0) ? we1 : we0;
    return (mcnt[n] == 0) && we && (w != 0) && (w == a);
  endfunction

  function automatic logic [31:0] m_rd(input int n, input int a);
    bit byp = (n == 0);
    if (a == 0) return 32'h0;
    if (byp && m_hit(n, 1, a)) return wd1 & wmask(n);
    if (byp && m_hit(n, 0, a)) return wd0 & wmask(n);
    return mr[n][a];
  endfunction

  function automatic logic m_rbusy(input int n, input int a);
    bit byp = (n == 0);
    return mb[n][a] && !(byp && (m_hit(n, 0, a) || m_hit(n, 1, a)));
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      mcnt[n] = 0;
      for (int i = 0; i < 32; i++) begin
        mr[n][i] = 32'h0;
        mb[n][i] = 1'b0;
      end
    end
  endtask

  task automatic model_update();
    for (int n = 0; n < 2; n++) begin
      int d  = dep(n);
      int w0 = int'(wa0) & (d - 1);
      int w1 = int'(wa1) & (d - 1);
      int ia = int'(iss_addr) & (d - 1);
      if (mcnt[n] == 0) begin
        if (we0 && w0 != 0) begin mr[n][w0] = wd0 & wmask(n); mb[n][w0] = 1'b0; end
        if (we1 && w1 != 0) begin mr[n][w1] = wd1 & wmask(n); mb[n][w1] = 1'b0; end
        if (iss_valid && ia != 0) mb[n][ia] = 1'b1;
        if (clr_req) mcnt[n] = 1;
      end else if (mcnt[n] < d) begin
        mr[n][mcnt[n]] = 32'h0;
        mb[n][mcnt[n]] = 1'b0;
        mcnt[n]++;
      end else begin
        mcnt[n] = 0;
      end
    end
  endtask

  task automatic check_model();
    for (int n = 0; n < 2; n++) begin
      int d  = dep(n);
      int nr = (n != 0) ? 4 : 3;
      for (int k = 0; k < nr; k++) begin
        int          a  = int'(ra_v[k]) & (d - 1);
        logic [31:0] ad = (n != 0) ? {16'h0, rd_b[k*16 +: 16]} : rd_a[k*32 +: 32];
        logic        ab = (n != 0) ? rbusy_b[k] : rbusy_a[k];
        chk($sformatf("rd_i%0d_p%0d_a%0d", n, k, a), ad, m_rd(n, a));
        chk($sformatf("rbusy_i%0d_p%0d_a%0d", n, k, a), {31'h0, ab}, {31'h0, m_rbusy(n, a)});
      end
      chk($sformatf("clr_busy_i%0d", n), {31'h0, (n != 0) ? clr_busy_b : clr_busy_a},
          {31'h0, mcnt[n] != 0});
      chk($sformatf("clr_done_i%0d", n), {31'h0, (n != 0) ? clr_done_b : clr_done_a},
          {31'h0, mcnt[n] == d});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    iss_valid = 0; iss_addr = 0; clr_req = 0;
    for (int k = 0; k < 4; k++) ra_v[k] = 0;
  endtask

  task automatic rand_inputs(input bit allow_clr);
    we0       = 1'($urandom_range(0, 1));
    we1       = 1'($urandom_range(0, 1));
    wa0       = 5'($urandom_range(0, 31));
    wa1       = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
    wd0       = $urandom;
    wd1       = $urandom;
    iss_valid = 1'($urandom_range(0, 1));
    iss_addr  = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
    clr_req   = allow_clr && ($urandom_range(0, 39) == 0);
    for (int k = 0; k < 4; k++)
      ra_v[k] = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
  endtask

  // Compare on the falling edge, then advance DUT and model on the rising edge.
  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic load_all();
    for (int a = 1; a < 32; a++) begin
      set_idle();
      we0 = 1; wa0 = 5'(a); wd0 = $urandom | 32'h1;
      settle(); tick();
    end
    set_idle();
  endtask

  // ---------------- main sequence ----------------
  int busy_a, busy_b, done_a_at, done_b_at, done_cnt;

  initial begin
    set_idle();
    model_reset();
    rst_n = 0;
    settle();
    chk("reset_rd_a", rd_a[31:0], 32'h0);
    chk("reset_rbusy_a", {29'h0, rbusy_a}, 32'h0);
    chk("reset_clr_busy_a", {31'h0, clr_busy_a}, 32'h0);
    tick();
    rst_n = 1;
    settle(); tick();

    // write then read back
    we0 = 1; wa0 = 5; wd0 = 32'hDEAD_BEEF;
    settle(); tick();
    set_idle(); ra_v[0] = 5;
    settle();
    chk("wr_rd5_a", rd_a[31:0], 32'hDEAD_BEEF);
    chk("wr_rd5_b", {16'h0, rd_b[15:0]}, 32'h0000_BEEF);
    tick();
    set_idle(); we0 = 1; wa0 = 0; wd0 = 32'h1234;
    settle(); tick();
    set_idle();
    settle();
    chk("wr_zero_a", rd_a[31:0], 32'h0);
    tick();

    // dual write to the same address
    we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h1; wd1 = 32'h2; ra_v[0] = 7;
    settle();
    chk("dual_byp_a", rd_a[31:0], 32'h2);
    chk("dual_nobyp_b", {16'h0, rd_b[15:0]}, 32'h0);
    tick();
    set_idle(); ra_v[0] = 7;
    settle();
    chk("dual_store_a", rd_a[31:0], 32'h2);
    chk("dual_store_b", {16'h0, rd_b[15:0]}, 32'h2);
    tick();

    // scoreboard
    set_idle(); iss_valid = 1; iss_addr = 9;
    settle(); tick();
    set_idle(); ra_v[0] = 9;
    settle();
    chk("sb_set_a", {31'h0, rbusy_a[0]}, 32'h1);
    tick();
    set_idle(); ra_v[0] = 9; we0 = 1; wa0 = 9; wd0 = 32'h99;
    settle();
    chk("sb_wr_mask_a", {31'h0, rbusy_a[0]}, 32'h0);
    chk("sb_wr_nomask_b", {31'h0, rbusy_b[0]}, 32'h1);
    tick();
    set_idle(); ra_v[0] = 9;
    settle();
    chk("sb_wr_clr_a", {31'h0, rbusy_a[0]}, 32'h0);
    tick();
    set_idle(); ra_v[0] = 9; we0 = 1; wa0 = 9; wd0 = 32'h77; iss_valid = 1; iss_addr = 9;
    settle(); tick();
    set_idle(); ra_v[0] = 9;
    settle();
    chk("sb_set_wins_a", {31'h0, rbusy_a[0]}, 32'h1);
    chk("sb_set_wins_b", {31'h0, rbusy_b[0]}, 32'h1);
    tick();

    // clear sequence, with traffic during it
    load_all();
    clr_req = 1;
    settle(); tick();
    busy_a = 0; busy_b = 0; done_a_at = 0; done_b_at = 0;
    for (int j = 1; j <= 40; j++) begin
      if (j <= 32) begin
        rand_inputs(1'b0);
      end else begin
        set_idle();
      end
      settle();
      if (clr_busy_a) busy_a++;
      if (clr_busy_b) busy_b++;
      if (clr_done_a && done_a_at == 0) done_a_at = j;
      if (clr_done_b && done_b_at == 0) done_b_at = j;
      tick();
    end
    chk("clr_len_a", busy_a, 32);
    chk("clr_done_at_a", done_a_at, 32);
    chk("clr_len_b", busy_b, 8);
    chk("clr_done_at_b", done_b_at, 8);
    for (int a = 0; a < 32; a++) begin
      set_idle(); ra_v[0] = 5'(a); ra_v[1] = 5'(31 - a);
      settle();
      chk($sformatf("post_clr_a%0d", a), rd_a[31:0], 32'h0);
      tick();
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs(1'b1);
      settle(); tick();
    end

    // reset in the middle of a clear
    set_idle();
    for (int i = 0; i < 40; i++) begin settle(); tick(); end
    load_all();
    clr_req = 1;
    settle(); tick();
    set_idle();
    for (int i = 0; i < 9; i++) begin settle(); tick(); end
    #1 rst_n = 0;
    ra_v[0] = 20; ra_v[1] = 31; ra_v[2] = 12;
    #1;
    model_reset();
    chk("abort_clr_busy_a", {31'h0, clr_busy_a}, 32'h0);
    chk("abort_clr_done_a", {31'h0, clr_done_a}, 32'h0);
    chk("abort_state_a", {30'h0, dbg_a}, 32'h0);
    chk("abort_rd20_a", rd_a[31:0], 32'h0);
    chk("abort_rd31_a", rd_a[63:32], 32'h0);
    chk("abort_rd12_a", rd_a[95:64], 32'h0);
    settle(); tick();
    rst_n = 1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      ra_v[0] = 5'($urandom_range(0, 31));
      settle();
      if (clr_done_a) done_cnt++;
      tick();
    end
    chk("abort_no_done_a", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
